// File: rtl/display_pkg.sv
// Shared definitions for the display arbiter: FSM encoding, source count,
// default hold time and nibble-slicing helpers.
package display_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int N_SRC           = 4;
  localparam int HOLD_CYCLES_DEF = 100000000;
  localparam int CNT_W_DEF       = 27;
  localparam int NIB_W           = 4;
  localparam int N_NIB           = 8;
  localparam int WORD_W          = NIB_W * N_NIB;

  // Nibble idx of a display word; idx 7 is bits 31:28.
  function automatic logic [NIB_W-1:0] nib(input logic [WORD_W-1:0] word,
                                           input logic [2:0]        idx);
    return word[{idx, 2'b00} +: NIB_W];
  endfunction

  function automatic logic [N_SRC-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker over four requesters; the source after
// 'last' has highest priority and 'last' itself has the lowest.
module rr_pick4
  import display_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       found
);

  logic [1:0] w_start;
  logic [3:0] w_rot;
  logic [1:0] w_ofs;

  assign w_start = last + 2'd1;

  // Rotate so that bit 0 is the first source to be scanned.
  always_comb begin
    w_rot = req;
    case (w_start)
      2'd0:    w_rot = req;
      2'd1:    w_rot = {req[0],   req[3:1]};
      2'd2:    w_rot = {req[1:0], req[3:2]};
      2'd3:    w_rot = {req[2:0], req[3]};
      default: w_rot = req;
    endcase
  end

  // Priority-encode the rotated request vector.
  always_comb begin
    w_ofs = 2'd0;
    found = 1'b1;
    casez (w_rot)
      4'b???1: w_ofs = 2'd0;
      4'b??10: w_ofs = 2'd1;
      4'b?100: w_ofs = 2'd2;
      4'b1000: w_ofs = 2'd3;
      default: found = 1'b0;
    endcase
  end

  assign pick = w_start + w_ofs;

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing an 8-digit seven-segment display between four
// sources, with a minimum hold per grant and an optional owner lock.
module display_arbiter
  import display_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  req,
  input  logic [WORD_W-1:0] data0,
  input  logic [WORD_W-1:0] data1,
  input  logic [WORD_W-1:0] data2,
  input  logic [WORD_W-1:0] data3,
  input  logic              lock,
  output logic [NIB_W-1:0]  seg7,
  output logic [NIB_W-1:0]  seg6,
  output logic [NIB_W-1:0]  seg5,
  output logic [NIB_W-1:0]  seg4,
  output logic [NIB_W-1:0]  seg3,
  output logic [NIB_W-1:0]  seg2,
  output logic [NIB_W-1:0]  seg1,
  output logic [NIB_W-1:0]  seg0,
  output logic [N_SRC-1:0]  grant,
  output logic [1:0]        owner,
  output logic              owner_valid,
  output logic              hold_done
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_PRE  = CNT_W'(HOLD_CYCLES - 2);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]         r_owner, w_owner_nxt;
  logic [N_SRC-1:0]   r_grant, w_grant_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_hold_done, w_hold_done_nxt;
  logic [WORD_W-1:0]  r_seg, w_seg_nxt;
  logic [1:0]         w_pick;
  logic               w_found;
  logic [WORD_W-1:0]  w_data_pick, w_data_own, w_seg_live;
  logic               w_expiry;

  function automatic logic [WORD_W-1:0] sel_data(input logic [1:0] idx,
                                                 input logic [WORD_W-1:0] d0,
                                                 input logic [WORD_W-1:0] d1,
                                                 input logic [WORD_W-1:0] d2,
                                                 input logic [WORD_W-1:0] d3);
    case (idx)
      2'd0:    return d0;
      2'd1:    return d1;
      2'd2:    return d2;
      2'd3:    return d3;
      default: return d0;
    endcase
  endfunction

  rr_pick4 u_pick (
    .req   (req),
    .last  (r_owner),
    .pick  (w_pick),
    .found (w_found)
  );

  assign w_data_pick = sel_data(w_pick,  data0, data1, data2, data3);
  assign w_data_own  = sel_data(r_owner, data0, data1, data2, data3);
  assign w_seg_live  = req[r_owner] ? w_data_own : r_seg;
  assign w_expiry    = (r_cnt == LP_LAST);

  // Next-state, counter and output-register logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_owner_nxt     = r_owner;
    w_grant_nxt     = r_grant;
    w_valid_nxt     = r_valid;
    w_hold_done_nxt = 1'b0;
    w_seg_nxt       = r_seg;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_HOLD;
          w_owner_nxt = w_pick;
          w_grant_nxt = onehot4(w_pick);
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_seg_nxt   = w_data_pick;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        w_seg_nxt = w_seg_live;
        if (!w_expiry) begin
          w_cnt_nxt       = r_cnt + LP_ONE;
          w_hold_done_nxt = (r_cnt == LP_PRE);
        end else if (lock) begin
          // Stall at expiry; hold_done already pulsed on the way in.
          w_cnt_nxt = LP_LAST;
        end else if (w_found) begin
          w_owner_nxt = w_pick;
          w_grant_nxt = onehot4(w_pick);
          w_cnt_nxt   = '0;
          w_seg_nxt   = w_data_pick;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_seg_nxt   = r_seg;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_owner     <= 2'd3;
      r_grant     <= 4'b0000;
      r_valid     <= 1'b0;
      r_hold_done <= 1'b0;
      r_seg       <= 32'h0000_0000;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_owner     <= w_owner_nxt;
      r_grant     <= w_grant_nxt;
      r_valid     <= w_valid_nxt;
      r_hold_done <= w_hold_done_nxt;
      r_seg       <= w_seg_nxt;
    end
  end

  assign seg7        = nib(r_seg, 3'd7);
  assign seg6        = nib(r_seg, 3'd6);
  assign seg5        = nib(r_seg, 3'd5);
  assign seg4        = nib(r_seg, 3'd4);
  assign seg3        = nib(r_seg, 3'd3);
  assign seg2        = nib(r_seg, 3'd2);
  assign seg1        = nib(r_seg, 3'd1);
  assign seg0        = nib(r_seg, 3'd0);
  assign grant       = r_grant;
  assign owner       = r_owner;
  assign owner_valid = r_valid;
  assign hold_done   = r_hold_done;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with a 4-cycle hold time.
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data0, data1, data2, data3;
  logic        lock;
  logic [3:0]  seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        owner_valid;
  logic        hold_done;
  logic [31:0] segs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  display_arbiter #(.HOLD_CYCLES(4), .CNT_W(27)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .data0       (data0),
    .data1       (data1),
    .data2       (data2),
    .data3       (data3),
    .lock        (lock),
    .seg7        (seg7),
    .seg6        (seg6),
    .seg5        (seg5),
    .seg4        (seg4),
    .seg3        (seg3),
    .seg2        (seg2),
    .seg1        (seg1),
    .seg0        (seg0),
    .grant       (grant),
    .owner       (owner),
    .owner_valid (owner_valid),
    .hold_done   (hold_done)
  );

  assign segs = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [1:0] exp_owner,
                        input logic exp_valid, input logic exp_hd);
    logic [3:0] exp_grant;
    exp_grant = exp_valid ? (4'b0001 << exp_owner) : 4'b0000;
    chk({tag, ".owner"}, 32'(owner),       32'(exp_owner));
    chk({tag, ".grant"}, 32'(grant),       32'(exp_grant));
    chk({tag, ".valid"}, 32'(owner_valid), 32'(exp_valid));
    chk({tag, ".hdone"}, 32'(hold_done),   32'(exp_hd));
  endtask

  function automatic logic [31:0] rr_data(input logic [1:0] idx);
    case (idx)
      2'd0:    return 32'h12345678;
      2'd1:    return 32'h11111111;
      2'd2:    return 32'h22222222;
      2'd3:    return 32'h33333333;
      default: return 32'h00000000;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    lock  = 1'b0;
    data0 = 32'h0;
    data1 = 32'h0;
    data2 = 32'h0;
    data3 = 32'h0;
    repeat (2) @(negedge clk);
    chk_st("rst", 2'd3, 1'b0, 1'b0);
    chk("rst.seg", segs, 32'h00000000);

    reset = 1'b0;
    req   = 4'b0001;
    data0 = 32'h12345678;
    data1 = 32'h11111111;
    data2 = 32'h22222222;
    data3 = 32'h33333333;
    @(negedge clk);
    chk_st("first", 2'd0, 1'b1, 1'b0);
    chk("first.seg", segs, 32'h12345678);

    // Full rotation with every source requesting.
    req = 4'b1111;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk_st("rr0", 2'd0, 1'b1, logic'(c == 3));
    end
    for (int k = 1; k <= 4; k++) begin
      for (int c = 0; c <= 3; c++) begin
        @(negedge clk);
        chk_st("rr", 2'(k % 4), 1'b1, logic'(c == 3));
        if (c == 0) chk("rr.seg", segs, rr_data(2'(k % 4)));
      end
    end

    // Owner 1 locked across expiry.
    @(negedge clk); chk_st("lk.c0", 2'd1, 1'b1, 1'b0);
    @(negedge clk); chk_st("lk.c1", 2'd1, 1'b1, 1'b0);
    @(negedge clk); chk_st("lk.c2", 2'd1, 1'b1, 1'b0);
    @(negedge clk); chk_st("lk.c3", 2'd1, 1'b1, 1'b1);
    lock = 1'b1;
    @(negedge clk); chk_st("lk.st1", 2'd1, 1'b1, 1'b0);
    @(negedge clk); chk_st("lk.st2", 2'd1, 1'b1, 1'b0);
    lock  = 1'b0;
    data2 = 32'hDEADBEEF;
    @(negedge clk); chk_st("unlk", 2'd2, 1'b1, 1'b0);
    chk("unlk.seg", segs, 32'hDEADBEEF);

    // Owner 2 drops its request; display freezes, then arbiter idles.
    req   = 4'b0000;
    data2 = 32'h00000000;
    @(negedge clk); chk_st("frz.c1", 2'd2, 1'b1, 1'b0);
    chk("frz.seg1", segs, 32'hDEADBEEF);
    @(negedge clk); chk_st("frz.c2", 2'd2, 1'b1, 1'b0);
    @(negedge clk); chk_st("frz.c3", 2'd2, 1'b1, 1'b1);
    chk("frz.seg3", segs, 32'hDEADBEEF);
    @(negedge clk); chk_st("idle", 2'd2, 1'b0, 1'b0);
    chk("idle.seg", segs, 32'hDEADBEEF);
    @(negedge clk); chk_st("idle2", 2'd2, 1'b0, 1'b0);

    // Only source 3 requests: it wins, tracks live data and re-wins itself.
    req = 4'b1000;
    @(negedge clk); chk_st("o3.c0", 2'd3, 1'b1, 1'b0);
    chk("o3.seg0", segs, 32'h33333333);
    data3 = 32'hCAFEF00D;
    @(negedge clk); chk_st("o3.c1", 2'd3, 1'b1, 1'b0);
    chk("o3.live", segs, 32'hCAFEF00D);
    @(negedge clk); chk_st("o3.c2", 2'd3, 1'b1, 1'b0);
    @(negedge clk); chk_st("o3.c3", 2'd3, 1'b1, 1'b1);
    data3 = 32'hA5A5A5A5;
    @(negedge clk); chk_st("o3.re", 2'd3, 1'b1, 1'b0);
    chk("o3.reseg", segs, 32'hA5A5A5A5);
    @(negedge clk); chk_st("o3.r1", 2'd3, 1'b1, 1'b0);
    @(negedge clk); chk_st("o3.r2", 2'd3, 1'b1, 1'b0);
    @(negedge clk); chk_st("o3.r3", 2'd3, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a hold.
    reset = 1'b1;
    #1;
    chk_st("arst", 2'd3, 1'b0, 1'b0);
    chk("arst.seg", segs, 32'h00000000);
    @(negedge clk); chk_st("arst2", 2'd3, 1'b0, 1'b0);
    reset = 1'b0;
    req   = 4'b0010;
    data1 = 32'h0F0F0F0F;
    @(negedge clk); chk_st("post", 2'd1, 1'b1, 1'b0);
    chk("post.seg", segs, 32'h0F0F0F0F);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
